// File: rtl/b16_mem_arbiter.sv
// Two-master sequencer for the board's external 16-bit asynchronous SRAM.
// Grants the CPU data port or the DMA/loader port, generates registered active-low strobes.
module b16_mem_arbiter #(
   parameter int l = 16
) (
   input  logic         clk,
   input  logic         nreset,
   input  logic [2:0]   wait_cfg,
   input  logic [l-1:0] cpu_addr,
   input  logic         cpu_r,
   input  logic [1:0]   cpu_w,
   input  logic [l-1:0] cpu_dwrite,
   output logic [l-1:0] cpu_data,
   output logic         cpu_ready,
   input  logic         dma_req,
   input  logic         dma_we,
   input  logic [1:0]   dma_be,
   input  logic [l-1:0] dma_addr,
   input  logic [l-1:0] dma_dwrite,
   output logic         dma_ack,
   output logic [l-1:0] dma_rdata,
   output logic [l-1:0] a,
   inout  tri   [l-1:0] d,
   output logic         rd_b,
   output logic         wr_b,
   output logic         ble_b,
   output logic         bhe_b
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;

   logic [1:0]   state_q, state_d;
   logic         owner_q, owner_d;
   logic         last_q, last_d;
   logic         we_q, we_d;
   logic [2:0]   cnt_q, cnt_d;
   logic [l-1:0] wdata_q, wdata_d;
   logic [l-1:0] a_q, a_d;
   logic         rd_b_q, rd_b_d;
   logic         wr_b_q, wr_b_d;
   logic [1:0]   lane_b_q, lane_b_d;
   logic         d_oe_q, d_oe_d;
   logic         dma_ack_q, dma_ack_d;
   logic [l-1:0] cpu_data_q, cpu_data_d;
   logic [l-1:0] dma_rdata_q, dma_rdata_d;

   logic         cpu_req;
   logic         cpu_is_wr;
   logic         grant_cpu;
   logic         grant_dma;
   logic         sel_we;
   logic [1:0]   sel_be;
   logic [l-1:0] sel_addr;
   logic [l-1:0] sel_wdata;

   // Byte address bit 0 never reaches the word-addressed SRAM.
   logic unused_addr_lsb;
   assign unused_addr_lsb = cpu_addr[0] ^ dma_addr[0];

   assign cpu_req   = cpu_r | (|cpu_w);
   assign cpu_is_wr = |cpu_w;

   // On a tie the master that was not served last wins.
   assign grant_cpu = cpu_req & (~dma_req | (last_q == OWN_DMA));
   assign grant_dma = dma_req & ~grant_cpu;

   always_comb begin
      sel_we    = 1'b0;
      sel_be    = 2'b11;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_dwrite;
      if (grant_dma) begin
         sel_we    = dma_we;
         sel_be    = dma_be;
         sel_addr  = dma_addr;
         sel_wdata = dma_dwrite;
      end else if (cpu_is_wr) begin
         sel_we = 1'b1;
         sel_be = cpu_w;
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      we_d        = we_q;
      cnt_d       = cnt_q;
      wdata_d     = wdata_q;
      a_d         = a_q;
      rd_b_d      = rd_b_q;
      wr_b_d      = wr_b_q;
      lane_b_d    = lane_b_q;
      d_oe_d      = d_oe_q;
      dma_ack_d   = 1'b0;
      cpu_data_d  = cpu_data_q;
      dma_rdata_d = dma_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (grant_cpu | grant_dma) begin
               state_d  = ST_ACCESS;
               owner_d  = grant_dma ? OWN_DMA : OWN_CPU;
               we_d     = sel_we;
               cnt_d    = wait_cfg;
               wdata_d  = sel_wdata;
               a_d      = {1'b0, sel_addr[l-1:1]};
               lane_b_d = ~sel_be;
               // A write with no lanes enabled still runs its cycles but stays off the bus.
               if (sel_we) begin
                  wr_b_d = ~(|sel_be);
                  d_oe_d = |sel_be;
               end else begin
                  rd_b_d = 1'b0;
               end
            end
         end

         ST_ACCESS: begin
            if (cnt_q != 3'd0) begin
               cnt_d = cnt_q - 3'd1;
            end else begin
               state_d  = ST_DONE;
               rd_b_d   = 1'b1;
               wr_b_d   = 1'b1;
               lane_b_d = 2'b11;
               if (!we_q) begin
                  if (owner_q == OWN_CPU) cpu_data_d  = d;
                  else                    dma_rdata_d = d;
               end
               if (owner_q == OWN_DMA) dma_ack_d = 1'b1;
            end
         end

         ST_DONE: begin
            // Write data was held on d for this cycle; release it now.
            state_d = ST_IDLE;
            d_oe_d  = 1'b0;
            last_d  = owner_q;
         end

         default: begin
            state_d  = ST_IDLE;
            rd_b_d   = 1'b1;
            wr_b_d   = 1'b1;
            lane_b_d = 2'b11;
            d_oe_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_CPU;
         last_q      <= OWN_DMA;
         we_q        <= 1'b0;
         cnt_q       <= 3'd0;
         wdata_q     <= '0;
         a_q         <= '0;
         rd_b_q      <= 1'b1;
         wr_b_q      <= 1'b1;
         lane_b_q    <= 2'b11;
         d_oe_q      <= 1'b0;
         dma_ack_q   <= 1'b0;
         cpu_data_q  <= '0;
         dma_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         we_q        <= we_d;
         cnt_q       <= cnt_d;
         wdata_q     <= wdata_d;
         a_q         <= a_d;
         rd_b_q      <= rd_b_d;
         wr_b_q      <= wr_b_d;
         lane_b_q    <= lane_b_d;
         d_oe_q      <= d_oe_d;
         dma_ack_q   <= dma_ack_d;
         cpu_data_q  <= cpu_data_d;
         dma_rdata_q <= dma_rdata_d;
      end
   end

   assign cpu_ready = ~cpu_req | ((state_q == ST_DONE) & (owner_q == OWN_CPU));
   assign dma_ack   = dma_ack_q;
   assign cpu_data  = cpu_data_q;
   assign dma_rdata = dma_rdata_q;
   assign a         = a_q;
   assign rd_b      = rd_b_q;
   assign wr_b      = wr_b_q;
   assign ble_b     = lane_b_q[0];
   assign bhe_b     = lane_b_q[1];
   assign d         = d_oe_q ? wdata_q : {l{1'bz}};

endmodule

// File: tb/tb_b16_mem_arbiter.sv
// Directed bench for b16_mem_arbiter with a small behavioural async-SRAM model.
module tb_b16_mem_arbiter;

   logic        clk = 1'b0;
   logic        nreset;
   logic [2:0]  wait_cfg;
   logic [15:0] cpu_addr;
   logic        cpu_r;
   logic [1:0]  cpu_w;
   logic [15:0] cpu_dwrite;
   logic [15:0] cpu_data;
   logic        cpu_ready;
   logic        dma_req;
   logic        dma_we;
   logic [1:0]  dma_be;
   logic [15:0] dma_addr;
   logic [15:0] dma_dwrite;
   logic        dma_ack;
   logic [15:0] dma_rdata;
   logic [15:0] a;
   wire  [15:0] d;
   logic        rd_b, wr_b, ble_b, bhe_b;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [0:255];
   logic        preload;

   always #5 clk = ~clk;

   b16_mem_arbiter #(.l(16)) dut (
      .clk(clk), .nreset(nreset), .wait_cfg(wait_cfg),
      .cpu_addr(cpu_addr), .cpu_r(cpu_r), .cpu_w(cpu_w), .cpu_dwrite(cpu_dwrite),
      .cpu_data(cpu_data), .cpu_ready(cpu_ready),
      .dma_req(dma_req), .dma_we(dma_we), .dma_be(dma_be), .dma_addr(dma_addr),
      .dma_dwrite(dma_dwrite), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
      .a(a), .d(d), .rd_b(rd_b), .wr_b(wr_b), .ble_b(ble_b), .bhe_b(bhe_b)
   );

   // SRAM model: drives d while rd_b is low, latches enabled lanes while wr_b is low.
   assign d = (!rd_b) ? mem[a[7:0]] : 16'hzzzz;

   always @(posedge clk) begin
      if (preload) begin
         mem[8'h81] <= 16'hBEEF;
         mem[8'h10] <= 16'h5566;
      end else if (!wr_b) begin
         if (!ble_b) mem[a[7:0]][7:0]  <= d[7:0];
         if (!bhe_b) mem[a[7:0]][15:8] <= d[15:8];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("check %-22s observed %h expected %h", tag, obs, exp);
   endtask

   initial begin
      nreset = 1'b0; wait_cfg = 3'd0; preload = 1'b1;
      cpu_addr = '0; cpu_r = 1'b0; cpu_w = 2'b00; cpu_dwrite = '0;
      dma_req = 1'b0; dma_we = 1'b0; dma_be = 2'b00; dma_addr = '0; dma_dwrite = '0;
      tick();
      preload = 1'b0;
      tick();

      // Reset state
      chk("rst_strobes", {rd_b, wr_b, ble_b, bhe_b}, 4'hF);
      chk("rst_a", a, 16'h0000);
      chk("rst_ack", dma_ack, 1'b0);
      chk("rst_cpu_data", cpu_data, 16'h0000);
      chk("rst_dma_rdata", dma_rdata, 16'h0000);
      chk("rst_ready", cpu_ready, 1'b1);

      // CPU read, byte address 0x0102, two wait states
      nreset = 1'b1;
      cpu_addr = 16'h0102; cpu_r = 1'b1; wait_cfg = 3'd2;
      #1;
      chk("rd_req_stall", cpu_ready, 1'b0);
      tick();
      chk("rd_a", a, 16'h0081);
      chk("rd_strobes_e1", {rd_b, wr_b, ble_b, bhe_b}, 4'h4);
      tick();
      chk("rd_strobes_e2", {rd_b, wr_b, ble_b, bhe_b}, 4'h4);
      tick();
      chk("rd_strobes_e3", {rd_b, wr_b, ble_b, bhe_b}, 4'h4);
      chk("rd_ready_e3", cpu_ready, 1'b0);
      tick();
      chk("rd_strobes_done", {rd_b, wr_b, ble_b, bhe_b}, 4'hF);
      chk("rd_ready_done", cpu_ready, 1'b1);
      chk("rd_cpu_data", cpu_data, 16'hBEEF);
      cpu_r = 1'b0;
      tick();

      // CPU high-byte write, no wait states
      cpu_w = 2'b10; cpu_dwrite = 16'h12AB; wait_cfg = 3'd0;
      tick();
      chk("wr_strobes_acc", {rd_b, wr_b, ble_b, bhe_b}, 4'hA);
      chk("wr_d_acc", d, 16'h12AB);
      chk("wr_ready_acc", cpu_ready, 1'b0);
      tick();
      chk("wr_strobes_done", {rd_b, wr_b, ble_b, bhe_b}, 4'hF);
      chk("wr_d_hold", d, 16'h12AB);
      chk("wr_ready_done", cpu_ready, 1'b1);
      cpu_w = 2'b00;
      tick();
      chk("wr_mem", mem[8'h81], 16'h12EF);
      chk("wr_cpu_data_hold", cpu_data, 16'hBEEF);

      // Simultaneous requests from reset: CPU, DMA, CPU, DMA
      nreset = 1'b0;
      tick();
      nreset = 1'b1;
      cpu_addr = 16'h0020; cpu_r = 1'b1;
      dma_req = 1'b1; dma_we = 1'b0; dma_be = 2'b11; dma_addr = 16'h0102;
      tick();
      chk("rr1_a_cpu", a, 16'h0010);
      tick();
      chk("rr1_ready", cpu_ready, 1'b1);
      chk("rr1_cpu_data", cpu_data, 16'h5566);
      chk("rr1_no_ack", dma_ack, 1'b0);
      tick();
      chk("rr1_idle_stall", cpu_ready, 1'b0);
      tick();
      chk("rr2_a_dma", a, 16'h0081);
      tick();
      chk("rr2_ack", dma_ack, 1'b1);
      chk("rr2_dma_rdata", dma_rdata, 16'h12EF);
      chk("rr2_cpu_data_hold", cpu_data, 16'h5566);
      chk("rr2_ready_low", cpu_ready, 1'b0);
      tick();
      chk("rr2_ack_pulse", dma_ack, 1'b0);
      tick();
      chk("rr3_a_cpu", a, 16'h0010);
      tick();
      chk("rr3_ready", cpu_ready, 1'b1);
      tick();
      tick();
      chk("rr4_a_dma", a, 16'h0081);
      dma_req = 1'b1;
      tick();
      chk("rr4_ack", dma_ack, 1'b1);
      dma_req = 1'b0; cpu_r = 1'b0;
      tick();

      // DMA write with no byte lanes, three wait states
      dma_req = 1'b1; dma_we = 1'b1; dma_be = 2'b00; dma_addr = 16'h0020;
      dma_dwrite = 16'hDEAD; wait_cfg = 3'd3;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk($sformatf("be0_strobes_e%0d", i), {rd_b, wr_b, ble_b, bhe_b}, 4'hF);
         chk($sformatf("be0_ack_e%0d", i), dma_ack, 1'b0);
      end
      tick();
      chk("be0_ack", dma_ack, 1'b1);
      dma_req = 1'b0;
      tick();
      chk("be0_mem", mem[8'h10], 16'h5566);

      // Reset in the middle of a long CPU read
      cpu_addr = 16'h0102; cpu_r = 1'b1; wait_cfg = 3'd7;
      tick();
      chk("mrst_rd_active", rd_b, 1'b0);
      tick();
      tick();
      nreset = 1'b0;
      tick();
      chk("mrst_strobes", {rd_b, wr_b, ble_b, bhe_b}, 4'hF);
      chk("mrst_a", a, 16'h0000);
      chk("mrst_cpu_data", cpu_data, 16'h0000);
      chk("mrst_dma_rdata", dma_rdata, 16'h0000);
      chk("mrst_no_ready", cpu_ready, 1'b0);
      nreset = 1'b1; wait_cfg = 3'd1;
      tick();
      chk("mrst2_a", a, 16'h0081);
      chk("mrst2_rd", rd_b, 1'b0);
      tick();
      chk("mrst2_stall", cpu_ready, 1'b0);
      tick();
      chk("mrst2_ready", cpu_ready, 1'b1);
      chk("mrst2_cpu_data", cpu_data, 16'h12EF);
      cpu_r = 1'b0;
      tick();

      // Read+write request is a write; wait_cfg change mid-access is ignored
      cpu_addr = 16'h0020; cpu_r = 1'b1; cpu_w = 2'b11; cpu_dwrite = 16'hCAFE;
      wait_cfg = 3'd1;
      tick();
      chk("rw_strobes_e1", {rd_b, wr_b, ble_b, bhe_b}, 4'h8);
      chk("rw_d", d, 16'hCAFE);
      wait_cfg = 3'd7;
      tick();
      chk("rw_strobes_e2", {rd_b, wr_b, ble_b, bhe_b}, 4'h8);
      chk("rw_stall", cpu_ready, 1'b0);
      tick();
      chk("rw_ready", cpu_ready, 1'b1);
      chk("rw_strobes_done", {rd_b, wr_b, ble_b, bhe_b}, 4'hF);
      cpu_r = 1'b0; cpu_w = 2'b00;
      tick();
      chk("rw_mem", mem[8'h10], 16'hCAFE);
      chk("rw_cpu_data_hold", cpu_data, 16'h12EF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/b16_mem_arbiter.md
# b16_mem_arbiter

Sequencing controller for the evaluation board's external 16-bit asynchronous SRAM. It shares the SRAM between two masters, the b16 CPU data port and a DMA/loader port. It generates the active-low SRAM strobes with a configurable wait-state count and stalls the CPU until its access completes. It replaces direct CPU-driven strobe generation in the board top level.

## Interface
Parameters:
- l, 16, data and byte-address width

Ports:
- clk  in  1  single system clock; all logic on rising edge
- nreset  in  1  reset, synchronous, active-low
- wait_cfg  in  3  strobe wait states (0..7), sampled at grant only
- cpu_addr  in  l  CPU byte address
- cpu_r  in  1  CPU read request
- cpu_w  in  2  CPU byte-lane write enables; [1]=high byte, [0]=low byte
- cpu_dwrite  in  l  CPU write data
- cpu_data  out  l  CPU read data (registered)
- cpu_ready  out  1  high = CPU may proceed; low = stall
- dma_req  in  1  DMA request, held until dma_ack
- dma_we  in  1  DMA direction, 1=write
- dma_be  in  2  DMA byte enables, same lane order as cpu_w
- dma_addr  in  l  DMA byte address
- dma_dwrite  in  l  DMA write data
- dma_ack  out  1  one-cycle completion pulse
- dma_rdata  out  l  DMA read data (registered)
- a  out  l  SRAM word address = {1'b0, addr[l-1:1]}
- d  inout  l  SRAM data bus
- rd_b, wr_b, ble_b, bhe_b  out  1 each  active-low SRAM strobes

## Operation
- CPU request: cpu_req = cpu_r | (|cpu_w).
  - If any cpu_w bit is set, the access is a write, even if cpu_r is also set.
  - Otherwise it is a read with both lanes enabled.
- cpu_ready = ~cpu_req | (state==DONE & owner==CPU). This is the only combinational output.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - All strobes high; d is Z.
  - If a request is pending, grant one master and latch: owner, address, direction, byte enables, write data, and cnt=wait_cfg. Then go to ACCESS.
  - If both masters request, round-robin applies: the master not granted last wins.
  - The last-grant register resets to DMA, so the CPU wins the first tie.
- ACCESS:
  - a is driven from the latched address.
  - Read: rd_b=0, ble_b/bhe_b=~be, d is Z.
  - Write: wr_b=0, ble_b/bhe_b=~be, d driven with the latched data.
  - Write with be=00: no strobe asserts, but the cycle count is unchanged.
  - If cnt≠0: decrement and stay. If cnt==0: a read captures d into the owner's read-data register; go to DONE.
- DONE:
  - All strobes high; a held.
  - Write data stays driven on d for one hold cycle.
  - CPU owner: cpu_ready=1. DMA owner: dma_ack=1.
  - Record the last grant; return to IDLE.
- Read data registers change only on a completed read by their own master. Otherwise they hold.
- wait_cfg changes during ACCESS have no effect on the current access.
- A master that drops its request after grant does not abort the access; it completes normally.

## Timing
- Reset (nreset low at an edge) gives on the next edge:
  - state=IDLE; strobes=1111; d=Z; a=0; dma_ack=0.
  - cpu_data=0; dma_rdata=0; last grant=DMA.
  - This applies mid-access too: the access is abandoned with no ack and no ready.
- Grant edge → ACCESS lasts wait_cfg+1 cycles → DONE lasts 1 cycle. Total is wait_cfg+3 cycles from request seen in IDLE to ready/ack.
- Read data is valid on cpu_data/dma_rdata in the DONE cycle and after.
- The earliest next grant is the edge ending DONE+IDLE. Back-to-back accesses are therefore wait_cfg+3 cycles apart.
- Strobes are registered: glitch-free, changing only on rising clk.
- d is never driven in the same cycle as rd_b=0.
- The CPU samples cpu_ready high at a rising edge and then presents its next request. Request inputs must be stable from grant until ready/ack.

## Test plan
- Reset, then CPU read at byte address 0x0102, wait_cfg=2, SRAM model returns 0xBEEF → a=0x0081, rd_b low 3 cycles, ble_b=bhe_b=0. cpu_ready rises 5 cycles after the request; cpu_data=0xBEEF.
- CPU write cpu_w=10, data 0x12AB, wait_cfg=0 → wr_b low 1 cycle with bhe_b=0, ble_b=1, d=0x12AB. d held through DONE, then Z. Model high byte=0x12, low byte unchanged.
- CPU and DMA both request from reset → CPU granted first. DMA is granted in the next IDLE; dma_ack is a single-cycle pulse; alternation continues while both hold requests.
- DMA write with dma_be=00, wait_cfg=3 → no wr_b/ble_b/bhe_b activity; dma_ack after 6 cycles; SRAM unchanged.
- nreset low during ACCESS of a CPU read (wait_cfg=7) → next edge strobes=1111, d=Z, cpu_data=0, no ready pulse. After release, a new read completes normally.
- cpu_r=1 with cpu_w=11 and wait_cfg change mid-ACCESS → performed as a write; duration uses the wait_cfg value latched at grant.
